// File: rtl/t11_mem_ctrl.sv
// rtl/t11_mem_ctrl.sv - T11 bus memory/peripheral controller: RAM, console TX FIFO, line clock, core reset sequencer
module t11_mem_ctrl #(
    parameter int          RAM_AW     = 12,
    parameter logic [15:0] MODE_WORD  = 16'hA000,
    parameter int          RST_CYCLES = 4,
    parameter logic [15:0] TICK_DIV   = 16'd16667
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        cpu_reset,
    input  logic [15:0] addr,
    input  logic [15:0] dout,
    input  logic        wr_n,
    output logic [15:0] din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq_lclk
);

    localparam int          RCW         = $clog2(RST_CYCLES + 1);
    localparam logic [15:0] TXCSR_ADDR  = 16'hFF70;
    localparam logic [15:0] TXBUF_ADDR  = 16'hFF72;
    localparam logic [15:0] LCLK_ADDR   = 16'hFF74;
    localparam logic [15:0] TICK_RELOAD = TICK_DIV - 16'd1;

    // din is driven from one of three registered sources so the RAM read
    // stays a plain synchronous read port.
    typedef enum logic [1:0] {
        SRC_MODE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_REG  = 2'd2
    } din_src_e;

    // Reset sequencer state
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic           cpu_reset_q, cpu_reset_d;

    // Read path state
    din_src_e       din_src_q, din_src_d;
    logic [15:0]    reg_rd_q, reg_rd_d;
    logic [15:0]    ram_rd_q;

    // TX FIFO state
    logic [3:0][7:0] fifo_q, fifo_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    // Line clock state
    logic [15:0]    tick_q, tick_d;
    logic           flag_q, flag_d;
    logic           en_q, en_d;
    logic           irq_q, irq_d;

    // Word RAM; contents survive reset
    logic [15:0]    ram [0:(2**RAM_AW)-1];

    // Decode and strobes
    logic                run;
    logic                wr_en;
    logic                sel_ram, sel_txcsr, sel_txbuf, sel_lclk;
    logic [RAM_AW-1:0]   ram_idx;
    logic                ram_we;
    logic                full, push, pop, push_ok, tick;
    logic                unused_addr0;

    // The core ignores the byte lane bit for word accesses
    assign unused_addr0 = addr[0];

    assign run       = ~cpu_reset_q;
    assign wr_en     = run & ~wr_n;
    assign sel_ram   = (addr[15:RAM_AW+1] == '0);
    assign sel_txcsr = (addr[15:1] == TXCSR_ADDR[15:1]);
    assign sel_txbuf = (addr[15:1] == TXBUF_ADDR[15:1]);
    assign sel_lclk  = (addr[15:1] == LCLK_ADDR[15:1]);
    assign ram_idx   = addr[RAM_AW:1];
    assign ram_we    = wr_en & sel_ram;

    assign full    = (cnt_q == 3'd4);
    assign pop     = run & (cnt_q != 3'd0) & tx_ready;
    assign push    = wr_en & sel_txbuf;
    assign push_ok = push & (~full | pop);
    assign tick    = run & (tick_q == 16'd0);

    assign cpu_reset = cpu_reset_q;
    assign tx_data   = fifo_q[rd_ptr_q];
    assign tx_valid  = (cnt_q != 3'd0);
    assign irq_lclk  = irq_q;

    // Output mux: every source is a flop, so din changes only at clk edges
    always_comb begin
        din = reg_rd_q;
        case (din_src_q)
            SRC_MODE: din = MODE_WORD;
            SRC_RAM:  din = ram_rd_q;
            default:  din = reg_rd_q;
        endcase
    end

    // RAM write port with write-first read so a same-word write is visible next cycle
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= dout;
            ram_rd_q     <= dout;
        end else begin
            ram_rd_q     <= ram[ram_idx];
        end
    end

    // Next-state for the reset sequencer, read mux, FIFO and line clock
    always_comb begin
        rst_cnt_d   = rst_cnt_q;
        cpu_reset_d = cpu_reset_q;
        din_src_d   = din_src_q;
        reg_rd_d    = 16'd0;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        tick_d      = tick_q;
        flag_d      = flag_q;
        en_d        = en_q;
        irq_d       = irq_q;

        // Count down once per cycle; the core leaves reset when the count hits zero
        if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RCW'(1);
        end
        cpu_reset_d = (rst_cnt_d != '0);

        // Register reads sample pre-edge state
        if (sel_txcsr) begin
            reg_rd_d = {ovf_q, 7'd0, ~full, 4'd0, cnt_q};
        end else if (sel_lclk) begin
            reg_rd_d = {8'd0, flag_q, en_q, 6'd0};
        end
        if (cpu_reset_d) begin
            din_src_d = SRC_MODE;
        end else if (sel_ram) begin
            din_src_d = SRC_RAM;
        end else begin
            din_src_d = SRC_REG;
        end

        // FIFO: a pop frees the slot a same-cycle push into a full FIFO needs
        if (push_ok) begin
            fifo_d[wr_ptr_q] = dout[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
        if (wr_en && sel_txcsr) begin
            ovf_d = 1'b0;
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end

        // Line clock: counter frozen while the core is in reset
        if (run) begin
            if (tick_q == 16'd0) begin
                tick_d = TICK_RELOAD;
            end else begin
                tick_d = tick_q - 16'd1;
            end
        end
        if (wr_en && sel_lclk) begin
            en_d = dout[6];
            if (!dout[7]) begin
                flag_d = 1'b0;
            end
        end
        // A tick beats a coincident clearing write
        if (tick) begin
            flag_d = 1'b1;
        end
        irq_d = flag_d & en_d;
    end

    // State registers; reset restarts the core reset sequence and drops all queued state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt_q   <= RCW'(RST_CYCLES);
            cpu_reset_q <= 1'b1;
            din_src_q   <= SRC_MODE;
            reg_rd_q    <= 16'd0;
            fifo_q      <= '0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            cnt_q       <= 3'd0;
            ovf_q       <= 1'b0;
            tick_q      <= TICK_RELOAD;
            flag_q      <= 1'b0;
            en_q        <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            cpu_reset_q <= cpu_reset_d;
            din_src_q   <= din_src_d;
            reg_rd_q    <= reg_rd_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            tick_q      <= tick_d;
            flag_q      <= flag_d;
            en_q        <= en_d;
            irq_q       <= irq_d;
        end
    end

endmodule
